// File: rtl/pc_fetch.sv
// Instruction fetch front end: one outstanding memory request, a one-entry
// output buffer, redirect handling with stale-response kill, and a retired-fetch counter.
module pc_fetch #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_VEC = 'h8000_0000,
    parameter int                STEP      = 4,
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              req_valid,
    output logic [XLEN-1:0]   req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready,
    output logic              misalign,
    output logic [CNT_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               kill_q, kill_d;
    logic [31:0]        inst_q, inst_d;
    logic [XLEN-1:0]    inst_pc_q, inst_pc_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    redir_pc;

    assign redir_pc = redirect_pc & ~ALIGN_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            kill_q     <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        cnt_d      = cnt_q;
        misalign_d = redirect_valid && ((redirect_pc & ALIGN_MASK) != '0);

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redir_pc;
            end
            S_REQ: begin
                if (req_ready) state_d = S_WAIT;
                // An accepted request to the old pc must have its response discarded.
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (req_ready) kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = rsp_data;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + XLEN'(STEP);
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    state_d = S_REQ;
                end
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign req_valid  = (state_q == S_REQ);
    assign req_addr   = pc_q;
    assign inst_valid = (state_q == S_OUT);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign misalign   = misalign_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, stall, redirects, misalign, wrap,
// mid-transaction reset, and counter saturation on a narrow-counter second instance.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid, req_ready, rsp_valid, inst_valid, inst_ready, misalign;
    logic [31:0] req_addr, rsp_data, inst, inst_pc, fetch_cnt;

    logic        req_valid2, inst_valid2, misalign2;
    logic [31:0] req_addr2, inst2, inst_pc2;
    logic [1:0]  fetch_cnt2;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;

    pc_fetch dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .misalign(misalign), .fetch_cnt(fetch_cnt)
    );

    pc_fetch #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid2), .req_addr(req_addr2), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inst_valid(inst_valid2),
        .inst(inst2), .inst_pc(inst_pc2), .inst_ready(inst_ready),
        .misalign(misalign2), .fetch_cnt(fetch_cnt2)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name);
        logic [1:0] exp_sat;
        exp_sat = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
        tests_run++;
        if (fetch_cnt !== 32'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL %s fetch_cnt: got %0d expected %0d", name, fetch_cnt, exp_cnt);
        end
        tests_run++;
        if (fetch_cnt2 !== exp_sat) begin
            tests_failed++;
            $display("FAIL %s sat_cnt: got %0d expected %0d", name, fetch_cnt2, exp_sat);
        end
    endtask

    // Entry: DUT in REQ presenting exp_addr. Exit: DUT back in REQ after the handshake.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        tests_run++;
        if (req_valid !== 1'b1 || req_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL fetch_req: got valid=%b addr=%h expected valid=1 addr=%h", req_valid, req_addr, exp_addr);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = data;
        tick();
        rsp_valid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b1 || inst !== data || inst_pc !== exp_addr) begin
            tests_failed++;
            $display("FAIL fetch_inst: got v=%b inst=%h pc=%h expected v=1 inst=%h pc=%h", inst_valid, inst, inst_pc, data, exp_addr);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exp_cnt++;
        chk_cnt("fetch_done");
    endtask

    task automatic chk_reset_vals(input string name);
        tests_run++;
        if (req_valid !== 1'b0 || req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || misalign !== 1'b0 || fetch_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s: got rv=%b ra=%h iv=%b i=%h ip=%h m=%b c=%0d expected 0/80000000/0/0/0/0/0",
                     name, req_valid, req_addr, inst_valid, inst, inst_pc, misalign, fetch_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0;
        #3;
        chk_reset_vals("reset_values");
        exp_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL boot_to_req: got valid=%b addr=%h expected valid=1 addr=80000000", req_valid, req_addr);
        end
    endtask

    task automatic test_sequential();
        do_fetch(32'h8000_0000, 32'h1111_0001);
        do_fetch(32'h8000_0004, 32'h1111_0002);
        do_fetch(32'h8000_0008, 32'h1111_0003);
    endtask

    task automatic test_stall();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'hCAFE_F00D;
        tick();
        rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (inst_valid !== 1'b1 || inst !== 32'hCAFE_F00D || inst_pc !== 32'h8000_000C || req_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got iv=%b i=%h ip=%h rv=%b expected 1/cafef00d/8000000c/0", i, inst_valid, inst, inst_pc, req_valid);
            end
            chk_cnt("stall_cnt");
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exp_cnt++;
        chk_cnt("stall_release");
    endtask

    task automatic test_redirect_wait();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (req_valid !== 1'b0 || misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_wait_hold: got rv=%b m=%b expected 0/0", req_valid, misalign);
        end
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        tick();
        rsp_valid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_1000) begin
            tests_failed++;
            $display("FAIL redir_wait_drop: got iv=%b rv=%b ra=%h expected 0/1/80001000", inst_valid, req_valid, req_addr);
        end
        do_fetch(32'h8000_1000, 32'h2222_0001);
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (misalign !== 1'b1 || req_valid !== 1'b1 || req_addr !== 32'h8000_0100) begin
            tests_failed++;
            $display("FAIL misalign_pulse: got m=%b rv=%b ra=%h expected 1/1/80000100", misalign, req_valid, req_addr);
        end
        tick();
        tests_run++;
        if (misalign !== 1'b0 || req_addr !== 32'h8000_0100) begin
            tests_failed++;
            $display("FAIL misalign_clear: got m=%b ra=%h expected 0/80000100", misalign, req_addr);
        end
        do_fetch(32'h8000_0100, 32'h3333_0001);
    endtask

    task automatic test_redirect_req_accept();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_2000; req_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; req_ready = 1'b0;
        tests_run++;
        if (req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_req_wait: got rv=%b expected 0", req_valid);
        end
        rsp_valid = 1'b1; rsp_data = 32'hBAD0_0001;
        tick();
        rsp_valid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_2000) begin
            tests_failed++;
            $display("FAIL redir_req_kill: got iv=%b rv=%b ra=%h expected 0/1/80002000", inst_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_redirect_out();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h4444_0001; tick(); rsp_valid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_3000; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        exp_cnt++;
        chk_cnt("redir_out_ready");
        tests_run++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_3000) begin
            tests_failed++;
            $display("FAIL redir_out_ready_req: got iv=%b rv=%b ra=%h expected 0/1/80003000", inst_valid, req_valid, req_addr);
        end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h4444_0002; tick(); rsp_valid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_4000;
        tick();
        redirect_valid = 1'b0;
        chk_cnt("redir_out_discard");
        tests_run++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_4000) begin
            tests_failed++;
            $display("FAIL redir_out_discard_req: got iv=%b rv=%b ra=%h expected 0/1/80004000", inst_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (misalign !== 1'b0 || req_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_redirect: got m=%b ra=%h expected 0/fffffffc", misalign, req_addr);
        end
        do_fetch(32'hFFFF_FFFC, 32'h5555_0001);
        tests_run++;
        if (req_addr !== 32'h0000_0000 || misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_zero: got ra=%h m=%b expected 00000000/0", req_addr, misalign);
        end
    endtask

    task automatic test_back_to_back();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_5000;
        rsp_valid = 1'b1; rsp_data = 32'hBAD0_0002;
        tick();
        redirect_valid = 1'b0; rsp_valid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_5000) begin
            tests_failed++;
            $display("FAIL redir_rsp_same: got iv=%b rv=%b ra=%h expected 0/1/80005000", inst_valid, req_valid, req_addr);
        end
        do_fetch(32'h8000_5000, 32'h6666_0001);
    endtask

    task automatic test_reset_mid();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk_reset_vals("reset_mid");
        chk_cnt("reset_mid_cnt");
        tick();
        rst = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'hBAD0_0003;
        #1;
        tests_run++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_boot: got rv=%b iv=%b expected 0/0", req_valid, inst_valid);
        end
        tick();
        tests_run++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_req: got rv=%b ra=%h iv=%b expected 1/80000000/0", req_valid, req_addr, inst_valid);
        end
        tick();
        rsp_valid = 1'b0;
        tests_run++;
        if (req_valid !== 1'b1 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_late_rsp: got rv=%b iv=%b expected 1/0", req_valid, inst_valid);
        end
        do_fetch(32'h8000_0000, 32'h7777_0001);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_misalign();
        test_redirect_req_accept();
        test_redirect_out();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
